// File: rtl/mult_pkg.sv
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared definitions for the multiplier-sharing arbiter slice:
//                default operand width / requester count, requester-id width
//                and the product-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_D_IN  = 8;
    localparam int ID_W      = $clog2(DEF_N_REQ);

    // A full signed product needs twice the operand width.
    function automatic int prod_w(input int d_in);
        return 2 * d_in;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_share_arb_if.sv
// ============================================================================
//  Module      : mult_share_arb_if
//  Description : Requester-side bus of the multiplier-sharing arbiter.
//                master = client datapaths, slave = arbiter.
//    req_valid  [N_REQ]       operand pair valid, one bit per requester
//    req_ready  [N_REQ]       accept, one bit per requester
//    req_a/b    [N_REQ*D_IN]  packed signed operands, slice i = [i*D_IN +: D_IN]
//    rsp_valid  [N_REQ]       one-hot, one-cycle result strobe
//    rsp_m      [2*D_IN]      signed product
//    rsp_id     [ID width]    owner of rsp_m
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_share_arb_if #(
    parameter int N_REQ = mult_pkg::DEF_N_REQ,
    parameter int D_IN  = mult_pkg::DEF_D_IN
);
    localparam int c_id_w = $clog2(N_REQ);

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*D_IN-1:0] req_a;
    logic [N_REQ*D_IN-1:0] req_b;
    logic [N_REQ-1:0]      rsp_valid;
    logic [2*D_IN-1:0]     rsp_m;
    logic [c_id_w-1:0]     rsp_id;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_m, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_m, rsp_id
    );

endinterface

`default_nettype wire

// File: rtl/mult_share_arb_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin picker. Scans the request
//                vector starting at i_ptr and wrapping at N; the first set
//                bit wins.
//    i_req   [N]       request vector
//    i_ptr   [ID]      highest-priority index (must be < N)
//    o_grant [N]       one-hot grant (all zero when no request)
//    o_idx   [ID]      index of the granted bit
//    o_any   [1]       some request was granted
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mult_pkg::*;
#(
    parameter int N = DEF_N_REQ
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int c_id_w = $clog2(N);

    int                w_pos;
    logic [c_id_w-1:0] w_sel;
    logic              w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        for (int k = 0; k < N; k++) begin
            // Modulo-N wrap without a divider; i_ptr + k never exceeds 2N-2.
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sel = c_id_w'(w_pos);
            if (!w_found && i_req[w_sel]) begin
                w_found        = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

    assign o_any = w_found;

endmodule

`default_nettype wire

// File: rtl/mult_share_arb.sv
// ============================================================================
//  Module      : mult_share_arb
//  Description : Time-shares one free-running booth_mult between N_REQ
//                requesters. Every mult_done is a slot boundary: the product
//                of the previous slot is returned to its owner and the next
//                round-robin winner's operands are loaded onto mult_a/mult_b.
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    bus          requester bus (mult_share_arb_if.slave)
//    mult_a/b     operands to booth_mult
//    mult_done    booth_mult done pulse
//    mult_m       booth_mult product
//    err_timeout  sticky watchdog flag
//  Build option: MULT_SHARE_ARB_WDOG_EN enables the in-flight watchdog
//                (TIMEOUT cycles without mult_done drops the operation);
//                without it err_timeout is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_share_arb
    import mult_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int D_IN    = DEF_D_IN,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mult_share_arb_if.slave         bus,
    output logic [D_IN-1:0]         mult_a,
    output logic [D_IN-1:0]         mult_b,
    input  logic                    mult_done,
    input  logic [prod_w(D_IN)-1:0] mult_m,
    output logic                    err_timeout
);

    localparam int c_id_w = $clog2(N_REQ);
    localparam int c_p_w  = prod_w(D_IN);

    generate
        if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_check
            $error("mult_share_arb: N_REQ must be 2..8 and TIMEOUT >= 1");
        end
    endgenerate

    logic              r_in_flight;
    logic [c_id_w-1:0] r_owner;
    logic [c_id_w-1:0] r_rr_ptr;
    logic [D_IN-1:0]   r_mult_a;
    logic [D_IN-1:0]   r_mult_b;
    logic [N_REQ-1:0]  r_rsp_valid;
    logic [c_p_w-1:0]  r_rsp_m;
    logic [c_id_w-1:0] r_rsp_id;

    logic [N_REQ-1:0]  w_grant;
    logic [c_id_w-1:0] w_idx;
    logic              w_any;
    logic [c_id_w-1:0] w_ptr_next;
    logic [N_REQ-1:0]  w_owner_oh;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Transfers only happen at slot boundaries, so ready is the grant gated
    // by mult_done.
    assign bus.req_ready = mult_done ? w_grant : '0;

    assign w_ptr_next = (w_idx == c_id_w'(N_REQ - 1)) ? '0 : w_idx + c_id_w'(1);
    assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

`ifdef MULT_SHARE_ARB_WDOG_EN
    localparam int c_wd_w = $clog2(TIMEOUT + 1);

    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_err_timeout;
    logic              w_wd_fire;

    // Fires on the edge that brings the counter to TIMEOUT, i.e. TIMEOUT
    // cycles after the last mult_done.
    assign w_wd_fire = r_in_flight && !mult_done &&
                       (r_wd_cnt == c_wd_w'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else if (mult_done) begin
            r_wd_cnt <= '0;
        end else if (r_in_flight) begin
            r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
            if (w_wd_fire) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_flight <= 1'b0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_rsp_valid <= '0;
            r_rsp_m     <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (mult_done) begin
                // Completion: mult_m holds the product of the operands issued
                // at the previous boundary; without an owner it is discarded.
                if (r_in_flight) begin
                    r_rsp_m     <= mult_m;
                    r_rsp_id    <= r_owner;
                    r_rsp_valid <= w_owner_oh;
                end
                // Issue or idle in the same edge so slots run back to back.
                if (w_any) begin
                    r_mult_a    <= bus.req_a[w_idx*D_IN +: D_IN];
                    r_mult_b    <= bus.req_b[w_idx*D_IN +: D_IN];
                    r_owner     <= w_idx;
                    r_in_flight <= 1'b1;
                    r_rr_ptr    <= w_ptr_next;
                end else begin
                    r_mult_a    <= '0;
                    r_mult_b    <= '0;
                    r_in_flight <= 1'b0;
                end
            end
`ifdef MULT_SHARE_ARB_WDOG_EN
            else if (w_wd_fire) begin
                r_in_flight <= 1'b0;
                r_mult_a    <= '0;
                r_mult_b    <= '0;
            end
`endif
        end
    end

    assign mult_a        = r_mult_a;
    assign mult_b        = r_mult_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_m     = r_rsp_m;
    assign bus.rsp_id    = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arb.sv
// ============================================================================
//  Module      : tb_mult_share_arb
//  Description : Self-checking bench for mult_share_arb (N_REQ=4, D_IN=8).
//                A behavioural booth_mult stand-in produces mult_m on each
//                mult_done from the operands currently on mult_a/mult_b.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_share_arb;
    import mult_pkg::*;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [D-1:0]  mult_a;
    logic [D-1:0]  mult_b;
    logic          mult_done = 1'b0;
    logic [15:0]   mult_m = '0;
    logic          err_timeout;

    mult_share_arb_if #(.N_REQ(N), .D_IN(D)) bus ();

    mult_share_arb #(
        .N_REQ   (N),
        .D_IN    (D),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_done   (mult_done),
        .mult_m      (mult_m),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  e_ready;
        logic [3:0]  e_rsp_v;
        logic [1:0]  e_id;
        logic [15:0] e_m;
    } vec_t;

    vec_t tbl [20];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the arbiter owes and what it holds.
    bit              m_inflight;
    int              m_owner;
    int              m_ptr;
    logic [7:0]      m_a;
    logic [7:0]      m_b;
    logic [15:0]     m_prod;
    bit              m_err;
    int              m_cnt;
    logic [3:0]      e_v;
    logic [ID_W-1:0] e_id;
    logic [15:0]     e_m;
    logic [3:0]      last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_inflight = 0; m_owner = 0; m_ptr = 0; m_a = '0; m_b = '0;
        m_prod = '0; m_err = 0; m_cnt = 0;
    endtask

    // One clock: drive at negedge, check combinational ready, then check the
    // registered outputs just after the rising edge.
    task automatic run_cycle(input logic done, input logic [3:0] valid,
                             input logic [31:0] a, input logic [31:0] b);
        int g;
        logic [3:0] exp_ready;
        @(negedge clk);
        bus.req_valid = valid;
        bus.req_a     = a;
        bus.req_b     = b;
        mult_done     = done;
        mult_m        = done ? 16'(int'($signed(mult_a)) * int'($signed(mult_b)))
                             : 16'($urandom);
        #1;
        g = done ? model_grant(valid) : -1;
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("req_ready", bus.req_ready, exp_ready);
        chk("mult_a", mult_a, m_a);
        chk("mult_b", mult_b, m_b);
        last_ready = bus.req_ready;
        @(posedge clk);
        #1;
        e_v = '0; e_id = '0; e_m = '0;
        if (done) begin
            m_cnt = 0;
            if (m_inflight) begin
                e_v = 4'(1 << m_owner); e_id = ID_W'(m_owner); e_m = m_prod;
            end
            if (g >= 0) begin
                m_a = a[g*8 +: 8];
                m_b = b[g*8 +: 8];
                m_prod = 16'(int'($signed(m_a)) * int'($signed(m_b)));
                m_owner = g; m_inflight = 1; m_ptr = (g + 1) % N;
            end else begin
                m_inflight = 0; m_a = '0; m_b = '0;
            end
        end
`ifdef MULT_SHARE_ARB_WDOG_EN
        else if (m_inflight) begin
            m_cnt++;
            if (m_cnt == TO) begin
                m_err = 1; m_inflight = 0; m_a = '0; m_b = '0;
            end
        end
`endif
        chk("rsp_valid", bus.rsp_valid, e_v);
        if (e_v != 0) begin
            chk("rsp_id", bus.rsp_id, e_id);
            chk("rsp_m", bus.rsp_m, e_m);
        end
        chk("err_timeout", err_timeout, m_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mult_done = 1'b0; bus.req_valid = '0;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_m", bus.rsp_m, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_ready", bus.req_ready, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //          valid  a             b             ready  rsp_v  id     m
        tbl[0]  = '{4'h0, 32'h00000000, 32'h00000000, 4'h0, 4'h0, 2'd0, 16'h0000};
        tbl[1]  = '{4'h1, 32'h00000080, 32'h0000007F, 4'h1, 4'h0, 2'd0, 16'h0000};
        tbl[2]  = '{4'h0, 32'h00000000, 32'h00000000, 4'h0, 4'h1, 2'd0, 16'hC080};
        tbl[3]  = '{4'hE, 32'h017F8000, 32'h007F8000, 4'h2, 4'h0, 2'd0, 16'h0000};
        tbl[4]  = '{4'hC, 32'h017F8000, 32'h007F8000, 4'h4, 4'h2, 2'd1, 16'h4000};
        tbl[5]  = '{4'h8, 32'h017F8000, 32'h007F8000, 4'h8, 4'h4, 2'd2, 16'h3F01};
        tbl[6]  = '{4'h0, 32'h00000000, 32'h00000000, 4'h0, 4'h8, 2'd3, 16'h0000};
        tbl[7]  = '{4'h0, 32'h00000000, 32'h00000000, 4'h0, 4'h0, 2'd0, 16'h0000};
        tbl[8]  = '{4'hF, 32'h04030201, 32'h03030303, 4'h1, 4'h0, 2'd0, 16'h0000};
        tbl[9]  = '{4'hF, 32'h04030201, 32'h03030303, 4'h2, 4'h1, 2'd0, 16'h0003};
        tbl[10] = '{4'hF, 32'h04030201, 32'h03030303, 4'h4, 4'h2, 2'd1, 16'h0006};
        tbl[11] = '{4'hF, 32'h04030201, 32'h03030303, 4'h8, 4'h4, 2'd2, 16'h0009};
        tbl[12] = '{4'hF, 32'h04030201, 32'h03030303, 4'h1, 4'h8, 2'd3, 16'h000C};
        tbl[13] = '{4'hF, 32'h04030201, 32'h03030303, 4'h2, 4'h1, 2'd0, 16'h0003};
        tbl[14] = '{4'hF, 32'h04030201, 32'h03030303, 4'h4, 4'h2, 2'd1, 16'h0006};
        tbl[15] = '{4'hF, 32'h04030201, 32'h03030303, 4'h8, 4'h4, 2'd2, 16'h0009};
        tbl[16] = '{4'h0, 32'h00000000, 32'h00000000, 4'h0, 4'h8, 2'd3, 16'h000C};
        tbl[17] = '{4'h2, 32'h00000500, 32'h0000F900, 4'h2, 4'h0, 2'd0, 16'h0000};
        tbl[18] = '{4'h2, 32'h00000500, 32'h0000F900, 4'h2, 4'h2, 2'd1, 16'hFFDD};
        tbl[19] = '{4'h0, 32'h00000000, 32'h00000000, 4'h0, 4'h2, 2'd1, 16'hFFDD};

        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        model_reset();
        do_reset();

        // Directed slots: one done cycle followed by three quiet cycles.
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b1, tbl[i].valid, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_ready", i), last_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_rsp_valid", i), bus.rsp_valid, tbl[i].e_rsp_v);
            if (tbl[i].e_rsp_v != 0) begin
                chk($sformatf("tbl%0d_rsp_id", i), bus.rsp_id, tbl[i].e_id);
                chk($sformatf("tbl%0d_rsp_m", i), bus.rsp_m, tbl[i].e_m);
            end
            repeat (3) run_cycle(1'b0, tbl[i].valid, tbl[i].a, tbl[i].b);
        end

        // Reset while requester 2 has an operation in flight.
        run_cycle(1'b1, 4'b0100, $urandom, $urandom);
        run_cycle(1'b0, 4'b0000, $urandom, $urandom);
        run_cycle(1'b0, 4'b0000, $urandom, $urandom);
        do_reset();
        run_cycle(1'b1, 4'b0000, $urandom, $urandom);
        chk("post_rst_discard", bus.rsp_valid, 0);
        run_cycle(1'b0, 4'b0000, $urandom, $urandom);

        // Randomized slots with varying gaps, including back-to-back dones.
        for (int s = 0; s < 300; s++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int c = 0; c < gap; c++) begin
                run_cycle(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
            end
            run_cycle(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
        end

`ifdef MULT_SHARE_ARB_WDOG_EN
        // mult_done stuck low after an issue.
        do_reset();
        run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);
        run_cycle(1'b1, 4'b1000, 32'h05000000, 32'h06000000);
        for (int k = 1; k <= TO + 4; k++) begin
            run_cycle(1'b0, 4'b0000, $urandom, $urandom);
            chk($sformatf("wd_err_k%0d", k), err_timeout, (k >= TO));
        end
        chk("wd_mult_a_cleared", mult_a, 0);
        run_cycle(1'b1, 4'b0000, 32'h0, 32'h0);
        chk("wd_dropped_no_rsp", bus.rsp_valid, 0);
        chk("wd_err_sticky", err_timeout, 1);
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
